// File: rtl/header_rx_framer_if.sv
// header_rx_framer_if: byte-stream input and header handshake bundle.
//   rx_data/rx_valid         : UART byte strobe into the framer
//   header/header_valid      : assembled header and its valid flag
//   header_ready             : consumer acceptance of the header
// Modports: master = upstream/consumer side, slave = framer side.
interface header_rx_framer_if #(
    parameter int unsigned HDR_W = 640
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [HDR_W-1:0] header;
    logic             header_valid;
    logic             header_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output header_ready,
        input  header,
        input  header_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  header_ready,
        output header,
        output header_valid
    );
endinterface

// File: rtl/header_rx_framer.sv
// header_rx_framer: assembles a SOF-delimited UART byte stream into one
// HDR_BYTES-byte block header and presents it on a valid/ready handshake.
// Frames that stall longer than TIMEOUT_CYCLES between bytes are discarded.
//
// Optional feature macro: HEADER_RX_CHECKSUM_EN
//   When defined, an 8-bit XOR of all header bytes is checked against one
//   extra byte following the header; a mismatch discards the frame.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   rx_if        : slave side of header_rx_framer_if
//                  (rx_data, rx_valid, header, header_valid, header_ready)
//   busy         : high while a frame is being received or checked
//   byte_count   : header bytes received in the current frame
//   frame_error  : one-cycle pulse when a frame is discarded
//
// Parameter constraint: 2**CNT_W must exceed HDR_BYTES.
module header_rx_framer #(
    parameter int unsigned HDR_BYTES      = 80,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 8680,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    header_rx_framer_if.slave     rx_if,
    output logic                  busy,
    output logic [CNT_W-1:0]      byte_count,
    output logic                  frame_error
);

    localparam int unsigned HDR_W = HDR_BYTES * 8;
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HDR_BYTES - 1);

`ifdef HEADER_RX_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2,
        CHK  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [HDR_W-1:0]    header_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [TMR_W-1:0]    timer;
    logic [TMR_W-1:0]    timer_nxt;
    logic                err_nxt;
    logic                busy_nxt;
    logic                timeout_c;
`ifdef HEADER_RX_CHECKSUM_EN
    logic [7:0]          csum;
    logic [7:0]          csum_nxt;
`endif

    // Inter-byte timeout fires only when no byte arrives in the same cycle.
    assign timeout_c = (timer == TMR_LAST) && !rx_if.rx_valid;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            rx_if.header       <= '0;
            rx_if.header_valid <= 1'b0;
            busy               <= 1'b0;
            byte_count         <= '0;
            frame_error        <= 1'b0;
            timer              <= '0;
`ifdef HEADER_RX_CHECKSUM_EN
            csum               <= '0;
`endif
        end else begin
            state              <= state_nxt;
            rx_if.header       <= header_nxt;
            rx_if.header_valid <= (state_nxt == HOLD);
            busy               <= busy_nxt;
            byte_count         <= cnt_nxt;
            frame_error        <= err_nxt;
            timer              <= timer_nxt;
`ifdef HEADER_RX_CHECKSUM_EN
            csum               <= csum_nxt;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        header_nxt = rx_if.header;
        cnt_nxt    = byte_count;
        timer_nxt  = timer;
        err_nxt    = 1'b0;
`ifdef HEADER_RX_CHECKSUM_EN
        csum_nxt   = csum;
`endif

        unique case (state)
            IDLE: begin
                // Non-SOF bytes are line noise between frames; drop silently.
                if (rx_if.rx_valid && (rx_if.rx_data == SOF_BYTE)) begin
                    state_nxt = RECV;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
`ifdef HEADER_RX_CHECKSUM_EN
                    csum_nxt  = '0;
`endif
                end
            end

            RECV: begin
                // Length-delimited: a SOF-valued byte here is ordinary data.
                if (rx_if.rx_valid) begin
                    header_nxt = {rx_if.header[HDR_W-9:0], rx_if.rx_data};
                    cnt_nxt    = byte_count + CNT_W'(1);
                    timer_nxt  = '0;
`ifdef HEADER_RX_CHECKSUM_EN
                    csum_nxt   = csum ^ rx_if.rx_data;
                    if (byte_count == CNT_LAST) begin
                        state_nxt = CHK;
                    end
`else
                    if (byte_count == CNT_LAST) begin
                        state_nxt = HOLD;
                    end
`endif
                end else if (timeout_c) begin
                    // Partial header stays in place but is never flagged valid.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    err_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

`ifdef HEADER_RX_CHECKSUM_EN
            CHK: begin
                if (rx_if.rx_valid) begin
                    timer_nxt = '0;
                    if (rx_if.rx_data == csum) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b1;
                    end
                end else if (timeout_c) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    timer_nxt = '0;
                    err_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
`endif

            HOLD: begin
                // header_valid is high throughout HOLD, so ready alone completes
                // the handshake. Incoming bytes are dropped here.
                if (rx_if.header_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef HEADER_RX_CHECKSUM_EN
        busy_nxt = (state_nxt == RECV) || (state_nxt == CHK);
`else
        busy_nxt = (state_nxt == RECV);
`endif
    end

endmodule

// File: tb/tb_header_rx_framer.sv
// tb_header_rx_framer: directed and randomized frames against a byte-array
// reference model of the expected header, checksum and timeout timing.
module tb_header_rx_framer;

    localparam int unsigned HDR_BYTES = 80;
    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned T         = 64;
    localparam int unsigned CNT_W     = 7;
    localparam logic [7:0]  SOF       = 8'hA5;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] byte_count;
    logic             frame_error;

    always #5 clk = ~clk;

    header_rx_framer_if #(.HDR_W(HDR_W)) bus ();

    header_rx_framer #(
        .HDR_BYTES      (HDR_BYTES),
        .SOF_BYTE       (SOF),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_if       (bus.slave),
        .busy        (busy),
        .byte_count  (byte_count),
        .frame_error (frame_error)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int err_pulses = 0;
    int hv_cycles  = 0;

    logic [7:0] frame [HDR_BYTES];

    // Independent observers of error pulses and valid cycles.
    always @(negedge clk) begin
        if (frame_error === 1'b1) err_pulses++;
        if (bus.header_valid === 1'b1) hv_cycles++;
    end

    task automatic check(input string tag, input logic [HDR_W-1:0] obs, input logic [HDR_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Expected header: frame byte i lands at bit position HDR_W-1-8*i.
    function automatic logic [HDR_W-1:0] model_header();
        logic [HDR_W-1:0] h = '0;
        for (int i = 0; i < HDR_BYTES; i++) h[HDR_W-1-8*i -: 8] = frame[i];
        return h;
    endfunction

    function automatic logic [7:0] model_csum();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < HDR_BYTES; i++) x = x ^ frame[i];
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Data bytes with random idle gaps; byte long_idx waits the longest legal gap.
    task automatic send_data(input int n, input int gap_max, input int long_idx);
        for (int i = 0; i < n; i++) begin
            if (i == long_idx) idle(T - 1);
            else idle(int'($urandom_range(gap_max, 0)));
            send_byte(frame[i]);
        end
    endtask

    task automatic close_frame();
`ifdef HEADER_RX_CHECKSUM_EN
        send_byte(model_csum());
`endif
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_valid"}, HDR_W'(bus.header_valid), HDR_W'(1));
        check({tag, "_header"}, bus.header, model_header());
        check({tag, "_busy"}, HDR_W'(busy), HDR_W'(0));
        check({tag, "_count"}, HDR_W'(byte_count), HDR_W'(HDR_BYTES));
    endtask

    task automatic handshake(input string tag);
        bus.header_ready = 1'b1;
        tick();
        bus.header_ready = 1'b0;
        check({tag, "_released"}, HDR_W'(bus.header_valid), HDR_W'(0));
    endtask

    task automatic nominal_data();
        for (int i = 0; i < HDR_BYTES; i++) frame[i] = 8'(i);
    endtask

    initial begin
        int e0;
        int h0;
        logic [HDR_W-1:0] held;
        logic [7:0] junk;

        reset = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.header_ready = 1'b0;

        // Asynchronous reset state, before any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst_header", bus.header, '0);
        check("rst_valid", HDR_W'(bus.header_valid), HDR_W'(0));
        check("rst_busy", HDR_W'(busy), HDR_W'(0));
        check("rst_count", HDR_W'(byte_count), HDR_W'(0));
        check("rst_err", HDR_W'(frame_error), HDR_W'(0));
        idle(3);
        reset = 1'b1;
        idle(2);

        // Nominal frame.
        nominal_data();
        send_byte(SOF);
        check("sof_busy", HDR_W'(busy), HDR_W'(1));
        check("sof_count", HDR_W'(byte_count), HDR_W'(0));
        send_data(HDR_BYTES, 0, -1);
        close_frame();
        check_hold("nominal");
        check("nominal_msb", HDR_W'(bus.header[HDR_W-1 -: 8]), HDR_W'(8'h00));
        check("nominal_lsb", HDR_W'(bus.header[7:0]), HDR_W'(8'h4F));

        // Hold with ready low while stray bytes arrive.
        held = model_header();
        for (int c = 0; c < 50; c++) begin
            if (c == 10 || c == 25 || c == 40) send_byte(8'($urandom));
            else tick();
        end
        check_hold("hold");
        check("hold_stable", bus.header, held);
        handshake("hold");
        check("idle_busy", HDR_W'(busy), HDR_W'(0));
        check("idle_header_kept", bus.header, held);

        // Junk before SOF is ignored.
        e0 = err_pulses;
        send_byte(8'h11);
        idle(2);
        send_byte(8'h22);
        check("junk_busy", HDR_W'(busy), HDR_W'(0));
        send_byte(SOF);
        send_data(HDR_BYTES, 3, -1);
        close_frame();
        check_hold("junk");
        check("junk_same", bus.header, held);
        check("junk_noerr", HDR_W'(err_pulses), HDR_W'(e0));
        handshake("junk");

        // Randomized frames with in-band SOF values and a maximal gap.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < HDR_BYTES; i++) frame[i] = 8'($urandom);
            frame[7] = SOF;
            for (int j = 0; j < 3; j++) begin
                junk = 8'($urandom);
                if (junk == SOF) junk = 8'h5A;
                send_byte(junk);
            end
            send_byte(SOF);
            send_data(HDR_BYTES, 6, int'($urandom_range(HDR_BYTES - 1, 0)));
            close_frame();
            check_hold($sformatf("rand%0d", f));
            idle(int'($urandom_range(5, 0)));
            handshake($sformatf("rand%0d", f));
        end

        // Inter-byte timeout after 40 bytes.
        nominal_data();
        e0 = err_pulses;
        h0 = hv_cycles;
        send_byte(SOF);
        send_data(40, 2, -1);
        check("to_count40", HDR_W'(byte_count), HDR_W'(40));
        idle(T - 1);
        check("to_not_yet", HDR_W'(frame_error), HDR_W'(0));
        check("to_busy_before", HDR_W'(busy), HDR_W'(1));
        tick();
        check("to_pulse", HDR_W'(frame_error), HDR_W'(1));
        check("to_count0", HDR_W'(byte_count), HDR_W'(0));
        check("to_busy_after", HDR_W'(busy), HDR_W'(0));
        tick();
        check("to_pulse_end", HDR_W'(frame_error), HDR_W'(0));
        check("to_one_pulse", HDR_W'(err_pulses - e0), HDR_W'(1));
        check("to_never_valid", HDR_W'(hv_cycles - h0), HDR_W'(0));
        send_byte(SOF);
        send_data(HDR_BYTES, 1, 20);
        close_frame();
        check_hold("after_to");
        handshake("after_to");

`ifdef HEADER_RX_CHECKSUM_EN
        // Bad checksum discards the frame; good checksum then accepted.
        nominal_data();
        e0 = err_pulses;
        send_byte(SOF);
        send_data(HDR_BYTES, 0, -1);
        check("chk_busy", HDR_W'(busy), HDR_W'(1));
        send_byte(8'hFF);
        check("chk_pulse", HDR_W'(frame_error), HDR_W'(1));
        check("chk_novalid", HDR_W'(bus.header_valid), HDR_W'(0));
        tick();
        check("chk_pulse_end", HDR_W'(frame_error), HDR_W'(0));
        check("chk_one_pulse", HDR_W'(err_pulses - e0), HDR_W'(1));
        send_byte(SOF);
        send_data(HDR_BYTES, 0, -1);
        send_byte(8'h00);
        check_hold("chk_good");
        handshake("chk_good");
`endif

        // Reset mid-frame.
        nominal_data();
        e0 = err_pulses;
        send_byte(SOF);
        send_data(30, 1, -1);
        #2 reset = 1'b0;
        #1;
        check("mrst_header", bus.header, '0);
        check("mrst_valid", HDR_W'(bus.header_valid), HDR_W'(0));
        check("mrst_busy", HDR_W'(busy), HDR_W'(0));
        check("mrst_count", HDR_W'(byte_count), HDR_W'(0));
        check("mrst_err", HDR_W'(frame_error), HDR_W'(0));
        idle(3);
        reset = 1'b1;
        idle(2);
        check("mrst_noerr", HDR_W'(err_pulses), HDR_W'(e0));
        send_byte(SOF);
        send_data(HDR_BYTES, 2, -1);
        close_frame();
        check_hold("after_rst");
        handshake("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
